// File: rtl/fifo_1r1w_flex.sv
// Ready/valid FIFO of any depth >= 2. Head entry lives in an output register and
// the rest in a circular array of depth_p-1 entries, so data_o never comes from storage.
module fifo_1r1w_flex #(
    parameter int width_p     = 8,
    parameter int depth_p     = 16,
    parameter int af_thresh_p = depth_p - 2,
    parameter int ae_thresh_p = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i,
    input  logic                       flush_i,
    output logic [$clog2(depth_p+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int cnt_w = $clog2(depth_p + 1);
    localparam int arr_d = depth_p - 1;
    localparam int ptr_w = (arr_d > 1) ? $clog2(arr_d) : 1;

    localparam logic [cnt_w-1:0] depth_c    = cnt_w'(depth_p);
    localparam logic [cnt_w-1:0] one_c      = cnt_w'(1);
    localparam logic [cnt_w-1:0] af_c       = cnt_w'(af_thresh_p);
    localparam logic [cnt_w-1:0] ae_c       = cnt_w'(ae_thresh_p);
    localparam logic [ptr_w-1:0] ptr_last_c = ptr_w'(arr_d - 1);

    logic [width_p-1:0] mem_q [arr_d];
    logic [width_p-1:0] head_q, head_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic [ptr_w-1:0]   wptr_q, wptr_d;
    logic [ptr_w-1:0]   rptr_q, rptr_d;
    logic               wr_en, rd_en, arr_empty, mem_we;

    // Pointers wrap by compare so non-power-of-two array sizes work.
    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        return (p == ptr_last_c) ? '0 : p + ptr_w'(1);
    endfunction

    assign ready_o        = (count_q < depth_c);
    assign valid_o        = (count_q != '0);
    assign data_o         = head_q;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= af_c);
    assign almost_empty_o = (count_q <= ae_c);

    always_comb begin
        head_d    = head_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_we    = 1'b0;
        wr_en     = valid_i & ready_o;
        rd_en     = valid_o & ready_i;
        // The array holds everything except the head entry.
        arr_empty = (count_q <= one_c);

        if (flush_i) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + one_c;
                2'b01:   count_d = count_q - one_c;
                default: count_d = count_q;
            endcase

            if (rd_en && !arr_empty) begin
                head_d = mem_q[rptr_q];
                rptr_d = ptr_next(rptr_q);
            end

            if (wr_en) begin
                if (!valid_o || (rd_en && arr_empty)) begin
                    head_d = data_i;
                end else begin
                    mem_we = 1'b1;
                    wptr_d = ptr_next(wptr_q);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Array contents need no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_fifo_1r1w_flex.sv
// Bench for fifo_1r1w_flex: a depth-5 and a depth-7 instance share one stimulus stream,
// each checked every cycle against a queue model, plus a constant vector table on depth 5.
module tb_fifo_1r1w_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i, valid_i, ready_i, flush_i;
    logic [7:0] data_i;

    logic       ready5, valid5, af5, ae5;
    logic [7:0] data5;
    logic [2:0] count5;
    logic       ready7, valid7, af7, ae7;
    logic [7:0] data7;
    logic [2:0] count7;

    fifo_1r1w_flex #(.width_p(8), .depth_p(5), .af_thresh_p(3), .ae_thresh_p(1)) u_dut5 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready5), .valid_o(valid5), .data_o(data5), .ready_i(ready_i),
        .flush_i(flush_i), .count_o(count5), .almost_full_o(af5), .almost_empty_o(ae5)
    );

    fifo_1r1w_flex #(.width_p(8), .depth_p(7)) u_dut7 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready7), .valid_o(valid7), .data_o(data7), .ready_i(ready_i),
        .flush_i(flush_i), .count_o(count7), .almost_full_o(af7), .almost_empty_o(ae7)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q5[$];
    logic [7:0] exp_q7[$];

    typedef struct {
        logic       v;
        logic       r;
        logic [7:0] d;
        int         c;
        logic       vo;
        logic [7:0] dout;
        logic       ro;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic v, logic r, logic [7:0] d, int c,
                                logic vo, logic [7:0] dout, logic ro);
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.c = c; t.vo = vo; t.dout = dout; t.ro = ro;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int s5;
        int s7;
        s5 = exp_q5.size();
        s7 = exp_q7.size();
        chk("m5_count", 32'(count5), s5);
        chk("m5_valid", 32'(valid5), 32'(s5 > 0));
        chk("m5_ready", 32'(ready5), 32'(s5 < 5));
        chk("m5_af",    32'(af5),    32'(s5 >= 3));
        chk("m5_ae",    32'(ae5),    32'(s5 <= 1));
        if (s5 > 0) chk("m5_data", 32'(data5), 32'(exp_q5[0]));
        chk("m7_count", 32'(count7), s7);
        chk("m7_valid", 32'(valid7), 32'(s7 > 0));
        chk("m7_ready", 32'(ready7), 32'(s7 < 7));
        chk("m7_af",    32'(af7),    32'(s7 >= 5));
        chk("m7_ae",    32'(ae7),    32'(s7 <= 1));
        if (s7 > 0) chk("m7_data", 32'(data7), 32'(exp_q7[0]));
    endtask

    // One clock: decide handshakes from the model, clock, update the model, compare.
    task automatic step();
        logic       rd5, wr5, rd7, wr7, clr;
        logic [7:0] d;
        rd5 = ready_i && (exp_q5.size() > 0);
        wr5 = valid_i && (exp_q5.size() < 5);
        rd7 = ready_i && (exp_q7.size() > 0);
        wr7 = valid_i && (exp_q7.size() < 7);
        clr = reset_i || flush_i;
        d   = data_i;
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q5.delete();
            exp_q7.delete();
        end else begin
            if (rd5) void'(exp_q5.pop_front());
            if (wr5) exp_q5.push_back(d);
            if (rd7) void'(exp_q7.pop_front());
            if (wr7) exp_q7.push_back(d);
        end
        check_model();
    endtask

    initial begin
        int pv;
        int pr;
        logic [7:0] tmp;

        tbl[0]  = mk(1, 0, 8'h10, 1, 1, 8'h10, 1);
        tbl[1]  = mk(1, 0, 8'h11, 2, 1, 8'h10, 1);
        tbl[2]  = mk(1, 0, 8'h12, 3, 1, 8'h10, 1);
        tbl[3]  = mk(1, 0, 8'h13, 4, 1, 8'h10, 1);
        tbl[4]  = mk(1, 0, 8'h14, 5, 1, 8'h10, 0);
        tbl[5]  = mk(1, 0, 8'h15, 5, 1, 8'h10, 0);
        tbl[6]  = mk(0, 1, 8'h00, 4, 1, 8'h11, 1);
        tbl[7]  = mk(0, 1, 8'h00, 3, 1, 8'h12, 1);
        tbl[8]  = mk(0, 1, 8'h00, 2, 1, 8'h13, 1);
        tbl[9]  = mk(0, 1, 8'h00, 1, 1, 8'h14, 1);
        tbl[10] = mk(0, 1, 8'h00, 0, 0, 8'h00, 1);
        tbl[11] = mk(1, 0, 8'h20, 1, 1, 8'h20, 1);
        tbl[12] = mk(1, 0, 8'h21, 2, 1, 8'h20, 1);
        tbl[13] = mk(1, 0, 8'h22, 3, 1, 8'h20, 1);
        tbl[14] = mk(1, 0, 8'h23, 4, 1, 8'h20, 1);
        tbl[15] = mk(1, 0, 8'h24, 5, 1, 8'h20, 0);
        tbl[16] = mk(1, 1, 8'h25, 4, 1, 8'h21, 1);
        tbl[17] = mk(1, 0, 8'h25, 5, 1, 8'h21, 0);
        tbl[18] = mk(0, 1, 8'h00, 4, 1, 8'h22, 1);
        tbl[19] = mk(0, 1, 8'h00, 3, 1, 8'h23, 1);
        tbl[20] = mk(0, 1, 8'h00, 2, 1, 8'h24, 1);
        tbl[21] = mk(0, 1, 8'h00, 1, 1, 8'h25, 1);
        tbl[22] = mk(0, 1, 8'h00, 0, 0, 8'h00, 1);

        // Reset for two cycles
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; data_i = 8'h00;
        step();
        step();
        chk("rst_count5", 32'(count5), 0);
        chk("rst_valid5", 32'(valid5), 0);
        chk("rst_ready5", 32'(ready5), 1);
        chk("rst_ae5",    32'(ae5),    1);
        chk("rst_af5",    32'(af5),    0);
        chk("rst_data5",  32'(data5),  0);
        chk("rst_count7", 32'(count7), 0);
        chk("rst_ready7", 32'(ready7), 1);
        chk("rst_ae7",    32'(ae7),    1);
        reset_i = 1'b0;

        // Fill, full-refusal, drain, full with simultaneous read
        for (int i = 0; i < 23; i++) begin
            valid_i = tbl[i].v;
            ready_i = tbl[i].r;
            data_i  = tbl[i].d;
            step();
            chk($sformatf("tbl%0d_count", i), 32'(count5), tbl[i].c);
            chk($sformatf("tbl%0d_valid", i), 32'(valid5), 32'(tbl[i].vo));
            chk($sformatf("tbl%0d_ready", i), 32'(ready5), 32'(tbl[i].ro));
            chk($sformatf("tbl%0d_af", i),    32'(af5),    32'(tbl[i].c >= 3));
            chk($sformatf("tbl%0d_ae", i),    32'(ae5),    32'(tbl[i].c <= 1));
            if (tbl[i].vo) chk($sformatf("tbl%0d_data", i), 32'(data5), 32'(tbl[i].dout));
        end

        // Continuous stream at occupancy 1
        valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tmp    = 8'(8'h80 + i);
            data_i = tmp;
            step();
            chk("wrap_count", 32'(count5), 1);
            chk("wrap_data",  32'(data5),  32'(tmp));
        end

        // Continuous stream at occupancy 3 exercises array pointer wrap
        flush_i = 1'b1; valid_i = 1'b0;
        step();
        flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'(8'hA0 + i);
            step();
        end
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_i = 8'(8'hB0 + i);
            step();
            chk("wrap3_count", 32'(count5), 3);
        end
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Flush with a simultaneous handshake discards everything
        valid_i = 1'b1; ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'(8'h30 + i);
            step();
        end
        chk("pre_flush_count", 32'(count5), 3);
        flush_i = 1'b1; ready_i = 1'b1; data_i = 8'h33;
        step();
        flush_i = 1'b0;
        chk("flush_count5", 32'(count5), 0);
        chk("flush_valid5", 32'(valid5), 0);
        chk("flush_ready5", 32'(ready5), 1);
        chk("flush_count7", 32'(count7), 0);
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("post_flush_valid", 32'(valid5), 0);
        end
        valid_i = 1'b1; ready_i = 1'b0; data_i = 8'h40;
        step();
        chk("post_flush_data", 32'(data5), 32'h40);
        valid_i = 1'b0; ready_i = 1'b1;
        step();
        chk("post_flush_empty", 32'(valid5), 0);

        // Random traffic with occasional flush
        pv = 50; pr = 50;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 1000 == 0) begin
                pv = int'($urandom_range(10, 90));
                pr = int'($urandom_range(10, 90));
            end
            valid_i = ($urandom_range(0, 99) < pv);
            ready_i = ($urandom_range(0, 99) < pr);
            flush_i = ($urandom_range(0, 299) == 0);
            data_i  = 8'($urandom);
            step();
        end
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("final_count5", 32'(count5), 0);
        chk("final_count7", 32'(count7), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_1r1w_flex.md
# fifo_1r1w_flex

Parametrised successor to the team's 1-read/1-write ready/valid FIFO. Supports any depth (not only powers of two) and drives `data_o` from a register, with no combinational path from storage. Adds a synchronous flush, an occupancy count, and programmable almost-full/almost-empty flags. It sits between stages of the sorting datapath wherever elastic buffering with back-pressure telemetry is needed.

## Interface
- `width_p`, default 8: data width in bits (≥1).
- `depth_p`, default 16: total capacity in entries (≥2, any integer).
- `af_thresh_p`, default `depth_p-2`: `almost_full_o` asserts when count ≥ this value. Legal range 1..`depth_p`.
- `ae_thresh_p`, default 1: `almost_empty_o` asserts when count ≤ this value. Legal range 0..`depth_p-1`.
- `clk_i`, in, 1: the single clock; all state updates on its rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `data_i`, in, `width_p`: write data.
- `valid_i`, in, 1: write request.
- `ready_o`, out, 1: space available. A write is accepted when `valid_i & ready_o`.
- `valid_o`, out, 1: head entry present.
- `data_o`, out, `width_p`: head entry, registered.
- `ready_i`, in, 1: consumer ready. A read occurs when `valid_o & ready_i`.
- `flush_i`, in, 1: synchronous discard of all contents.
- `count_o`, out, `$clog2(depth_p+1)`: number of entries held.
- `almost_full_o`, out, 1: asserted when `count_o` ≥ `af_thresh_p`.
- `almost_empty_o`, out, 1: asserted when `count_o` ≤ `ae_thresh_p`.

## Operation
- **Storage structure.** Storage is one output register (head) plus a circular array of `depth_p-1` entries. `count_o` counts both.
- **Pointers.** Write and read pointers index the array. Each increments by 1 and wraps from `depth_p-2` to 0 by explicit compare, not by natural overflow.
- **`ready_o`** = (count < `depth_p`).
- **`valid_o`** = head register occupied, which is equivalent to count > 0.
- **Both outputs are functions of registered state only.** Neither depends combinationally on `valid_i`, `ready_i` or `flush_i`.
- **Write with the head empty, or being read in the same cycle while the array is empty:** `data_i` loads directly into the head register.
- **Otherwise, a write** goes to the array at the write pointer.
- **Read with the array non-empty:** the head register reloads from the array at the read pointer, and the read pointer advances.
- **Read with the array empty and no simultaneous write:** the head becomes empty.
- **Count update:**
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- **Simultaneous read and write when full:** `ready_o` is 0, so only the read occurs and the count drops by 1. There is no pass-through when full.
- **Empty with `valid_i` high:** no combinational bypass. `valid_o` rises the cycle after acceptance.
- **Flush (`flush_i`=1):**
  - Next state is: count = 0, both pointers = 0, head empty.
  - Any handshake in that cycle is discarded: the write is dropped and the read is not counted.
  - Flush has priority over reads and writes, and reset has priority over flush.
- **Almost flags:** `almost_full_o` and `almost_empty_o` derive from the count register, so they track `count_o` exactly.

## Timing
- **Reset values:**
  - `valid_o`=0, `ready_o`=1, `count_o`=0.
  - `almost_full_o`=0, unless `af_thresh_p`=0, which is illegal.
  - `almost_empty_o`=1.
  - `data_o`=0.
  - Both pointers = 0.
- **Write-to-read latency:** 1 cycle. A write accepted at edge N makes `valid_o`=1 with that data after edge N.
- **Throughput:** one write and one read per cycle sustained, at any occupancy 1..`depth_p-1`.
- **Data stability:** `data_o` stays stable while `valid_o`=1 and `ready_i`=0. `data_o` is don't-care while `valid_o`=0.
- **Reset or flush mid-burst:** takes effect at the next edge. Contents are lost, and `ready_o` is 1 in the following cycle.
- **Count updates:** `count_o` and both flags update at the same edge as the handshake that changes occupancy.

## Test plan
- **Reset:** assert `reset_i` for 2 cycles → `valid_o`=0, `ready_o`=1, `count_o`=0, `almost_empty_o`=1.
- **Fill and drain (`depth_p`=5, `af_thresh_p`=3):**
  - Write 0x10..0x14 with `ready_i`=0 → `ready_o`=0 after 5th write, `count_o`=5, `almost_full_o` high from count 3.
  - Then drain → data out 0x10..0x14 in order.
- **Wrap (`depth_p`=5):** stream 20 items with `valid_i`=`ready_i`=1 continuously → count holds at 1, no drops, output order = input order, pointers wrap with no gaps.
- **Full with simultaneous read:** when full, `valid_i`=`ready_i`=1 → one read, write refused, count 5→4; next cycle the write is accepted.
- **Flush:** with 3 entries, `flush_i`=1 together with `valid_i`=1 and `ready_i`=1 → next cycle count 0, `valid_o`=0; the offered write does not appear later.
- **Random stall (`depth_p`=7):** random `valid_i`/`ready_i` for 10k cycles checked against a scoreboard model → `count_o` and flags match the model each cycle, and no data loss or reordering.
